block_grid_sequencer: RTL and testbench
=======================================

// Module: block_grid_sequencer
// PURPOSE
//  Sequences one shared 2-bit block-sprite ROM across a NCOL x NROW playfield of cells.
//  Tracks the raster from hcount/vcount and computes the ROM address incrementally.
//  Looks up each cell's colour code in an internal cell-colour array and emits an 8-bit pixel.
//  Also arbitrates game-logic writes into that array against display reads.
// PARAMETERS
//  X0       208     left pixel column of board
//  Y0       40      top pixel row of board
//  CELL_W   16      cell width, pixels (ROM row length)
//  CELL_H   16      cell height, pixels
//  NCOL     10      cells per row (<=16)
//  NROW     20      cell rows (<=32)
//  PALETTE  64'h..  8 x 8-bit colours; code i at bits [8i+7:8i]; code 0 = empty
// PORTS
//  vclk      in   1   pixel clock
//  rst       in   1   reset, asynchronous, active-high
//  hcount    in   11  raster column
//  vcount    in   10  raster line
//  rom_addr  out  13  address to block ROM
//  rom_data  in   2   ROM pixel (synchronous ROM, 1-cycle read latency)
//  wr_req    in   1   cell write request; hold until wr_ack
//  wr_col    in   4   target column
//  wr_row    in   5   target row
//  wr_color  in   3   colour code to store
//  wr_ack    out  1   1-cycle pulse: write completed or rejected
//  wr_err    out  1   valid with wr_ack; 1 = col/row out of range, array unchanged
//  pixel_out out  8   pixel colour
//  pixel_en  out  1   1 = pixel_out is board content for the pixel 3 clocks earlier
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all counters 0; cell array all 0.
//   - rom_addr=0, pixel_out=8'h00, pixel_en=0, wr_ack=0, wr_err=0.
//  Regions:
//   - inx: X0 <= hcount < X0+NCOL*CELL_W.
//   - iny: Y0 <= vcount < Y0+NROW*CELL_H.
//  FSM:
//   - IDLE: waits for vcount==Y0 with hcount < X0.
//     Then clears row=0, yin=0, ybase=0 and goes to WAIT_X.
//   - WAIT_X: on hcount==X0, clears col=0, xin=0 and goes to DRAW.
//   - DRAW: each clock xin++.
//     When xin==CELL_W-1: xin=0, col++.
//     Leaving inx goes to LINE_END.
//   - LINE_END (1 clk): yin++, ybase+=CELL_W.
//     When yin==CELL_H-1: yin=0, ybase=0, row++.
//     If row was NROW-1 and yin was CELL_H-1, go to IDLE; otherwise go to WAIT_X.
//  Address arithmetic:
//   - No multipliers; rom_addr = ybase + xin.
//   - ybase is 13 bits; max CELL_W*CELL_H-1 with no overflow.
//  Pipeline (cycle t = hcount sampled in DRAW):
//   - t+1: rom_addr registered; colour code of (row,col) registered.
//   - t+2: rom_data valid.
//   - t+3: pixel_out/pixel_en registered.
//   - Outside DRAW: rom_addr holds, and the pipeline carries pixel_en=0.
//  Colour map at t+3, when code==0 or rom_data==00:
//   - pixel_out=8'h00; pixel_en=1 if the pixel is board content, else 0.
//  Colour map, otherwise:
//   - rom_data==11 -> 8'hFF.
//   - rom_data 01/10 -> PALETTE[code].
//  Write arbitration:
//   - Display owns the array while state==DRAW.
//   - A write is serviced only in a clock with state!=DRAW and wr_req=1.
//   - Servicing stores wr_color and pulses wr_ack next clock.
//   - A request pending at DRAW entry waits; there is no loss and no double write.
//   - After wr_ack, a fresh request needs wr_req to drop for at least 1 clk.
//  Boundaries:
//   - wr_col>=NCOL or wr_row>=NROW: wr_ack=1, wr_err=1, array unchanged.
//   - A write to the cell currently displayed can't tear: it lands between lines.
//   - Raster jumping out of region mid-DRAW (e.g. vcount wrap): FSM returns to IDLE at next vcount<Y0.
//  Reset mid-frame:
//   - All state clears, outputs black, and the array clears.
//   - Drawing resumes cleanly at the next frame's Y0; no partial frame.
// TESTING
//  1. Reset; array empty; full frame -> pixel_out=8'h00 everywhere; pixel_en=1 only on board, 3 clk after inx.
//  2. Write (col3,row0,code5), ROM model row0=01,11,00..
//     -> at hcount X0+48+k: rom_addr=k, pixel_out=PALETTE[5], 8'hFF, 8'h00 at +3 clk.
//  3. Line Y0+1 col 0 -> rom_addr starts at CELL_W (16).
//     Line Y0+CELL_H -> row=1, rom_addr restarts at 0.
//  4. wr_req asserted at hcount=X0+5 -> wr_ack not before the board-line end; exactly one pulse; array updated once.
//  5. wr_col=12 (>=NCOL) -> wr_ack=1, wr_err=1; readback frame unchanged.
//  6. rst pulsed at vcount=Y0+50 -> outputs 0 immediately; next frame draws from row 0 with empty array.

Source files
------------

// File: rtl/block_grid_sequencer.sv
// Walks one shared 2-bit block-sprite ROM across an NCOL x NROW grid of cells, colouring each
// pixel from a cell-colour array that game logic can rewrite when the display isn't using it.
module block_grid_sequencer #(
    parameter int          X0      = 208,
    parameter int          Y0      = 40,
    parameter int          CELL_W  = 16,
    parameter int          CELL_H  = 16,
    parameter int          NCOL    = 10,
    parameter int          NROW    = 20,
    parameter logic [63:0] PALETTE = 64'hC3A5_9678_5A3C_1E00
) (
    input  logic        vclk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [12:0] rom_addr,
    input  logic [1:0]  rom_data,
    input  logic        wr_req,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [2:0]  wr_color,
    output logic        wr_ack,
    output logic        wr_err,
    output logic [7:0]  pixel_out,
    output logic        pixel_en
);
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  WAIT_X   = 2'd1;
    localparam logic [1:0]  DRAW     = 2'd2;
    localparam logic [1:0]  LINE_END = 2'd3;

    localparam logic [10:0] XS    = 11'(X0);
    localparam logic [10:0] XE    = 11'(X0 + NCOL * CELL_W);
    localparam logic [9:0]  YS    = 10'(Y0);
    localparam logic [9:0]  YE    = 10'(Y0 + NROW * CELL_H);
    localparam logic [7:0]  XLAST = 8'(CELL_W - 1);
    localparam logic [7:0]  YLAST = 8'(CELL_H - 1);
    localparam logic [12:0] YSTEP = 13'(CELL_W);
    localparam logic [4:0]  RLAST = 5'(NROW - 1);
    localparam int          CW    = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int          RW    = (NROW > 1) ? $clog2(NROW) : 1;

    logic [1:0]  state_q, state_d;
    logic [3:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [7:0]  xin_q, xin_d;
    logic [7:0]  yin_q, yin_d;
    logic [12:0] ybase_q, ybase_d;
    logic [2:0]  cells_q [NROW][NCOL];

    logic [12:0] rom_addr_q;
    logic        vld_p1, vld_p2;
    logic [2:0]  code_p1, code_p2;
    logic [7:0]  pixel_q;
    logic        pixel_en_q;
    logic        wr_ack_q, wr_err_q, wr_busy_q;

    logic inx, iny, active, wr_go, wr_bad;

    function automatic logic [7:0] color_map(input logic [2:0] code, input logic [1:0] pix);
        if (code == 3'd0 || pix == 2'b00) return 8'h00;
        else if (pix == 2'b11)            return 8'hFF;
        else                              return PALETTE[{code, 3'b000} +: 8];
    endfunction

    assign inx = (hcount >= XS) && (hcount < XE);
    assign iny = (vcount >= YS) && (vcount < YE);
    // The hcount==X0 clock in WAIT_X already draws pixel X0, so drawing starts exactly on the board edge.
    assign active = inx && iny &&
                    ((state_q == DRAW) || ((state_q == WAIT_X) && (hcount == XS)));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        xin_d   = xin_q;
        yin_d   = yin_q;
        ybase_d = ybase_q;
        if (active) begin
            if (xin_q == XLAST) begin
                xin_d = '0;
                col_d = col_q + 4'd1;
            end else begin
                xin_d = xin_q + 8'd1;
            end
        end
        case (state_q)
            IDLE: begin
                if (vcount == YS && hcount < XS) begin
                    state_d = WAIT_X;
                    row_d   = '0;
                    yin_d   = '0;
                    ybase_d = '0;
                    col_d   = '0;
                    xin_d   = '0;
                end
            end
            WAIT_X: if (hcount == XS) state_d = DRAW;
            DRAW:   if (!inx) state_d = LINE_END;
            default: begin
                col_d = '0;
                xin_d = '0;
                if (yin_q == YLAST) begin
                    yin_d   = '0;
                    ybase_d = '0;
                    row_d   = row_q + 5'd1;
                end else begin
                    yin_d   = yin_q + 8'd1;
                    ybase_d = ybase_q + YSTEP;
                end
                state_d = (row_q == RLAST && yin_q == YLAST) ? IDLE : WAIT_X;
            end
        endcase
        if (state_q != IDLE && vcount < YS) state_d = IDLE;
    end

    // Writes wait for a non-drawing clock; wr_busy_q blocks a re-service until wr_req drops.
    assign wr_bad = ({1'b0, wr_col} >= 5'(NCOL)) || ({1'b0, wr_row} >= 6'(NROW));
    assign wr_go  = wr_req && !wr_busy_q && (state_q != DRAW) && !active;

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            xin_q     <= '0;
            yin_q     <= '0;
            ybase_q   <= '0;
            wr_busy_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            for (int r = 0; r < NROW; r++)
                for (int c = 0; c < NCOL; c++)
                    cells_q[r][c] <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            xin_q     <= xin_d;
            yin_q     <= yin_d;
            ybase_q   <= ybase_d;
            wr_busy_q <= wr_go || (wr_busy_q && wr_req);
            wr_ack_q  <= wr_go;
            wr_err_q  <= wr_go && wr_bad;
            if (wr_go && !wr_bad)
                cells_q[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_color;
        end
    end

    // Stage p1: ROM address and cell colour code; stage p2: ROM data returns; stage p3: pixel
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            pixel_q    <= 8'h00;
            pixel_en_q <= 1'b0;
        end else begin
            if (active) rom_addr_q <= ybase_q + {5'd0, xin_q};
            vld_p1     <= active;
            vld_p2     <= vld_p1;
            pixel_en_q <= vld_p2;
            pixel_q    <= vld_p2 ? color_map(code_p2, rom_data) : 8'h00;
        end
    end

    always_ff @(posedge vclk) begin
        code_p1 <= cells_q[row_q[RW-1:0]][col_q[CW-1:0]];
        code_p2 <= code_p1;
    end

    assign rom_addr  = rom_addr_q;
    assign wr_ack    = wr_ack_q;
    assign wr_err    = wr_err_q;
    assign pixel_out = pixel_q;
    assign pixel_en  = pixel_en_q;
endmodule

// File: tb/tb_block_grid_sequencer.sv
// Directed bench for block_grid_sequencer on a shrunken 4x3-cell board with a short raster.
module tb_block_grid_sequencer;
    localparam int HT = 80;
    localparam int VT = 60;
    localparam int X0 = 8;
    localparam int Y0 = 4;
    localparam int CWID = 16;
    localparam int CHGT = 16;
    localparam int NC = 4;
    localparam int NR = 3;

    logic        vclk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [12:0] rom_addr;
    logic [1:0]  rom_data;
    logic        wr_req = 1'b0;
    logic [3:0]  wr_col = '0;
    logic [4:0]  wr_row = '0;
    logic [2:0]  wr_color = '0;
    logic        wr_ack, wr_err;
    logic [7:0]  pixel_out;
    logic        pixel_en;

    int checks = 0;
    int errors = 0;
    int h = 0;
    int v = 0;
    logic [2:0] mdl [NR][NC];

    block_grid_sequencer #(
        .X0(X0), .Y0(Y0), .CELL_W(CWID), .CELL_H(CHGT), .NCOL(NC), .NROW(NR),
        .PALETTE(64'hC3A5_9678_5A3C_1E00)
    ) dut (
        .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
        .wr_ack(wr_ack), .wr_err(wr_err), .pixel_out(pixel_out), .pixel_en(pixel_en)
    );

    always #5 vclk = ~vclk;

    function automatic logic [1:0] rom_fn(input logic [12:0] a);
        case (a[1:0])
            2'd0:    return 2'b01;
            2'd1:    return 2'b11;
            2'd2:    return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge vclk) rom_data <= rom_fn(rom_addr);

    function automatic logic [7:0] pal(input logic [2:0] c);
        case (c)
            3'd1:    return 8'h1E;
            3'd2:    return 8'h3C;
            3'd3:    return 8'h5A;
            3'd4:    return 8'h78;
            3'd5:    return 8'h96;
            3'd6:    return 8'hA5;
            3'd7:    return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    // {pixel_en, pixel_out} expected for raster position (hh, vv)
    function automatic logic [8:0] exp_px(input int hh, input int vv);
        int c, r, a;
        logic [1:0] rp;
        logic [2:0] code;
        if (hh < X0 || hh >= X0 + NC * CWID || vv < Y0 || vv >= Y0 + NR * CHGT) return 9'h000;
        c = (hh - X0) / CWID;
        r = (vv - Y0) / CHGT;
        a = ((vv - Y0) % CHGT) * CWID + (hh - X0) % CWID;
        rp = rom_fn(13'(a));
        code = mdl[r][c];
        if (code == 3'd0 || rp == 2'b00) return {1'b1, 8'h00};
        if (rp == 2'b11) return {1'b1, 8'hFF};
        return {1'b1, pal(code)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge vclk);
        #1;
        if (h == HT - 1) begin
            h = 0;
            v = (v == VT - 1) ? 0 : v + 1;
        end else begin
            h++;
        end
        hcount = 11'(h);
        vcount = 10'(v);
    endtask

    task automatic wait_pos(input int tv, input int th, input string tag);
        int n = 0;
        while (!(v == tv && h == th) && n < 2 * HT * VT) begin
            tick();
            n++;
        end
        chk({tag, " reached"}, 32'(v == tv && h == th), 32'd1);
    endtask

    // Runs the raster until it next returns to (0,0), checking every pixel three clocks late.
    task automatic run_frame(input string tag);
        logic [8:0] q[$];
        logic [8:0] e;
        int bad = 0;
        int ens = 0;
        do begin
            q.push_back(exp_px(h, v));
            tick();
            if (q.size() == 3) begin
                e = q.pop_front();
                if ({pixel_en, pixel_out} !== e) begin
                    if (bad == 0)
                        $display("  first differing pixel in %s near v=%0d h=%0d: got %h want %h",
                                 tag, v, h, {pixel_en, pixel_out}, e);
                    bad++;
                end
                if (pixel_en) ens++;
            end
        end while (!(h == 0 && v == 0));
        chk({tag, " bad pixels"}, 32'(bad), 32'd0);
        chk({tag, " board pixel count"}, 32'(ens), 32'(NC * CWID * NR * CHGT));
    endtask

    task automatic do_write(input int c, input int r, input int color, input logic err_exp,
                            input string tag, output int ah, output int av);
        int n = 0;
        int extra = 0;
        wr_col = 4'(c);
        wr_row = 5'(r);
        wr_color = 3'(color);
        wr_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!wr_ack && n < 400);
        chk({tag, " ack"}, 32'(wr_ack), 32'd1);
        chk({tag, " err"}, 32'(wr_err), 32'(err_exp));
        ah = h;
        av = v;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_ack) extra++;
        end
        wr_req = 1'b0;
        tick();
        if (wr_ack) extra++;
        chk({tag, " single ack"}, 32'(extra), 32'd0);
        if (!err_exp) mdl[r][c] = 3'(color);
    endtask

    initial begin
        int ah, av, cnt;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                mdl[r][c] = '0;
        repeat (3) @(posedge vclk);
        #1;
        chk("reset rom_addr", 32'(rom_addr), 32'd0);
        chk("reset pixel_out", 32'(pixel_out), 32'd0);
        chk("reset pixel_en", 32'(pixel_en), 32'd0);
        chk("reset wr_ack", 32'(wr_ack), 32'd0);
        chk("reset wr_err", 32'(wr_err), 32'd0);
        rst = 1'b0;

        run_frame("empty frame");

        do_write(3, 0, 5, 1'b0, "write c3r0", ah, av);
        wait_pos(Y0, X0 + 48, "col3 row0 line0");
        tick();
        chk("col3 k0 rom_addr", 32'(rom_addr), 32'd0);
        tick();
        chk("col3 k1 rom_addr", 32'(rom_addr), 32'd1);
        tick();
        chk("col3 k2 rom_addr", 32'(rom_addr), 32'd2);
        chk("col3 k0 pixel", 32'(pixel_out), 32'h96);
        chk("col3 k0 en", 32'(pixel_en), 32'd1);
        tick();
        chk("col3 k1 pixel", 32'(pixel_out), 32'hFF);
        tick();
        chk("col3 k2 pixel", 32'(pixel_out), 32'h00);
        chk("col3 k2 en", 32'(pixel_en), 32'd1);

        wait_pos(Y0 + 1, X0, "line Y0+1");
        tick();
        chk("line1 rom_addr", 32'(rom_addr), 32'd16);
        wait_pos(Y0 + CHGT - 1, X0, "last line of row0");
        tick();
        chk("line15 rom_addr", 32'(rom_addr), 32'd240);
        wait_pos(Y0 + CHGT, X0, "row1 line0");
        tick();
        chk("row1 rom_addr", 32'(rom_addr), 32'd0);
        wait_pos(0, 0, "frame end");
        run_frame("frame after write");

        wait_pos(Y0 + 2, X0 + 5, "mid draw");
        do_write(1, 2, 3, 1'b0, "write during draw", ah, av);
        chk("draw write ack line", 32'(av), 32'(Y0 + 2));
        chk("draw write ack column", 32'(ah), 32'(X0 + NC * CWID + 2));
        wait_pos(0, 0, "frame end 2");
        run_frame("frame after draw write");

        do_write(12, 0, 7, 1'b1, "bad col", ah, av);
        do_write(0, 3, 7, 1'b1, "bad row", ah, av);
        run_frame("frame after rejected writes");

        wait_pos(Y0 + 36, 30, "pre-reset point");
        chk("pre-reset pixel", 32'(pixel_out), 32'h5A);
        chk("pre-reset en", 32'(pixel_en), 32'd1);
        rst = 1'b1;
        #2;
        chk("midframe reset pixel_out", 32'(pixel_out), 32'd0);
        chk("midframe reset pixel_en", 32'(pixel_en), 32'd0);
        chk("midframe reset rom_addr", 32'(rom_addr), 32'd0);
        chk("midframe reset wr_ack", 32'(wr_ack), 32'd0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                mdl[r][c] = '0;
        cnt = 0;
        while (!(h == 0 && v == 0)) begin
            tick();
            if (pixel_en) cnt++;
        end
        chk("no partial frame after reset", 32'(cnt), 32'd0);
        run_frame("frame after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
